// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry pipeline register with a skid slot.
// The main register M drives the outputs. The skid register S catches the one beat
// that can arrive while the consumer stalls. This lets in_ready be a pure function
// of flops, with no combinational path from out_ready.
// flush kills all held beats and zeroes their control bits. Payloads keep their
// values through a flush.
module pipe_skid_reg #(
   parameter int DATA_W = 16,
   parameter int CTRL_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            stateR;
   logic              rdyEnR;
   logic [CTRL_W-1:0] mCtrlR;
   logic [DATA_W-1:0] mDataR;
   logic [CTRL_W-1:0] sCtrlR;
   logic [DATA_W-1:0] sDataR;

   logic              ixS;
   logic              oxS;

   // Handshake qualifiers; both depend only on flops and the peer's valid/ready.
   assign ixS = in_valid & in_ready;
   assign oxS = out_valid & out_ready;

   // FSM and storage: flush dominates, then the per-state move rules.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateR <= EMPTY;
         rdyEnR <= 1'b0;
         mCtrlR <= {CTRL_W{1'b0}};
         mDataR <= {DATA_W{1'b0}};
         sCtrlR <= {CTRL_W{1'b0}};
         sDataR <= {DATA_W{1'b0}};
      end else begin
         // rdy_en rises on the first edge after release and then stays high.
         rdyEnR <= 1'b1;
         if (flush) begin
            // A same-cycle OX has already been sampled by the consumer.
            // A same-cycle IX is simply not stored.
            stateR <= EMPTY;
            mCtrlR <= {CTRL_W{1'b0}};
            sCtrlR <= {CTRL_W{1'b0}};
         end else begin
            case (stateR)
               EMPTY: begin
                  if (ixS) begin
                     mCtrlR <= in_ctrl;
                     mDataR <= in_data;
                     stateR <= HALF;
                  end else begin
                     stateR <= EMPTY;
                  end
               end
               HALF: begin
                  if (ixS && oxS) begin
                     // Head leaves and the new beat replaces it directly.
                     mCtrlR <= in_ctrl;
                     mDataR <= in_data;
                     stateR <= HALF;
                  end else if (ixS) begin
                     // Consumer stalled: the new beat parks in the skid slot.
                     sCtrlR <= in_ctrl;
                     sDataR <= in_data;
                     stateR <= FULL;
                  end else if (oxS) begin
                     stateR <= EMPTY;
                  end else begin
                     stateR <= HALF;
                  end
               end
               FULL: begin
                  // in_ready is low here, so only the head can move.
                  if (oxS) begin
                     mCtrlR <= sCtrlR;
                     mDataR <= sDataR;
                     stateR <= HALF;
                  end else begin
                     stateR <= FULL;
                  end
               end
               default: begin
                  stateR <= EMPTY;
               end
            endcase
         end
      end
   end

   // Output decode: every output is taken from a flop, never from an input.
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      occupancy = 2'd0;
      out_ctrl  = {CTRL_W{1'b0}};
      out_data  = mDataR;
      case (stateR)
         EMPTY: begin
            out_valid = 1'b0;
            in_ready  = rdyEnR;
            occupancy = 2'd0;
         end
         HALF: begin
            out_valid = 1'b1;
            in_ready  = rdyEnR;
            occupancy = 2'd1;
            out_ctrl  = mCtrlR;
         end
         FULL: begin
            out_valid = 1'b1;
            in_ready  = 1'b0;
            occupancy = 2'd2;
            out_ctrl  = mCtrlR;
         end
         default: begin
            out_valid = 1'b0;
            in_ready  = 1'b0;
            occupancy = 2'd0;
         end
      endcase
   end

endmodule
